// File: rtl/pc_pkg.sv
// Shared definitions for the Hack-style program counter and its optional return stack
// (return stack built only when PC_CALL_STACK_EN is defined).
package pc_pkg;

  localparam int          PC_WIDTH     = 16;
  localparam logic [15:0] PC_RESET_VEC = 16'h0000;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CLR,
    PC_PUSH,
    PC_POP
  } pc_op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack used by pc16_counter when PC_CALL_STACK_EN is defined.
// Reset clears only the entry count; the storage array is left untouched.
module pc_ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [AW-1:0]    top_idx;
  logic             wr_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign top_idx = count_q[AW-1:0] - 1'b1;
  assign rdata   = mem[top_idx];
  // pop has priority so a simultaneous push never lands in the slot being vacated
  assign wr_en   = push && !pop && !full;

  always_comb begin
    count_d = count_q;
    if (pop && !empty) begin
      count_d = count_q - 1'b1;
    end else if (wr_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pc16_counter.sv
// Hack-style program counter: hold / increment / load / clear, with an optional
// call/return stack (push, pop, stk_*) compiled in when PC_CALL_STACK_EN is defined.
module pc16_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(PC_RESET_VEC),
  parameter int               STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap
`ifdef PC_CALL_STACK_EN
  ,
  input  logic             push,
  input  logic             pop,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
`endif
);

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc16_counter: STACK_DEPTH must be a power of two >= 2");
  end

  pc_op_t           op;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_inc;
  logic             wrap_q;
  logic             wrap_d;

  assign out_inc = out_q + WIDTH'(1);

`ifdef PC_CALL_STACK_EN
  logic             stk_push;
  logic             stk_pop;
  logic             stk_full_w;
  logic             stk_empty_w;
  logic [WIDTH-1:0] stk_top;
  logic             err_q;
  logic             err_d;

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .wdata (out_inc),
    .rdata (stk_top),
    .full  (stk_full_w),
    .empty (stk_empty_w)
  );

  assign stk_full  = stk_full_w;
  assign stk_empty = stk_empty_w;
  assign stk_err   = err_q;
`endif

  always_comb begin
    op = PC_HOLD;
    if (clr) begin
      op = PC_CLR;
`ifdef PC_CALL_STACK_EN
    end else if (pop) begin
      op = PC_POP;
    end else if (push) begin
      op = PC_PUSH;
`endif
    end else if (load) begin
      op = PC_LOAD;
    end else if (inc) begin
      op = PC_INC;
    end
  end

  // A rejected push/pop still wins the decode, so load/inc are suppressed that cycle
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
`ifdef PC_CALL_STACK_EN
    err_d    = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    case (op)
      PC_INC: begin
        out_d  = out_inc;
        wrap_d = &out_q;
      end
      PC_LOAD: out_d = in;
      PC_CLR:  out_d = RESET_VAL;
`ifdef PC_CALL_STACK_EN
      PC_PUSH: begin
        if (stk_full_w) begin
          err_d = 1'b1;
        end else begin
          stk_push = 1'b1;
          out_d    = in;
        end
      end
      PC_POP: begin
        if (stk_empty_w) begin
          err_d = 1'b1;
        end else begin
          stk_pop = 1'b1;
          out_d   = stk_top;
        end
      end
`endif
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= RESET_VAL;
      wrap_q <= 1'b0;
`ifdef PC_CALL_STACK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
`ifdef PC_CALL_STACK_EN
      err_q  <= err_d;
`endif
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_pc16_counter.sv
// Self-checking bench for pc16_counter; covers the return stack when PC_CALL_STACK_EN is defined.
module tb_pc16_counter;

`ifdef PC_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pc_in = '0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        clr = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] out;
  logic        wrap;
`ifdef PC_CALL_STACK_EN
  logic        stk_empty;
  logic        stk_full;
  logic        stk_err;
`endif

  int checks = 0;
  int failures = 0;

  // reference state: PC value, stack as a queue, expected one-cycle pulses
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stk[$];
  logic        m_wrap = 1'b0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  pc16_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (pc_in),
    .load  (load),
    .inc   (inc),
    .clr   (clr),
    .out   (out),
    .wrap  (wrap)
`ifdef PC_CALL_STACK_EN
    ,
    .push      (push),
    .pop       (pop),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_edge();
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (clr) begin
      m_pc = 16'h0000;
    end else if (STK_EN && pop) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (STK_EN && push) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = pc_in;
      end
    end else if (load) begin
      m_pc = pc_in;
    end else if (inc) begin
      m_wrap = (m_pc == 16'hFFFF);
      m_pc   = m_pc + 16'd1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_pc));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
`ifdef PC_CALL_STACK_EN
    chk({tag, ".err"}, 32'(stk_err), 32'(m_err));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"}, 32'(stk_full), 32'(m_stk.size() == DEPTH));
`endif
  endtask

  // one clock: update the model from the inputs the DUT samples, then compare
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    $display("step %-10s in=%h ld=%b inc=%b clr=%b push=%b pop=%b -> out=%h wrap=%b",
             tag, pc_in, load, inc, clr, push, pop, out, wrap);
    check_model(tag);
  endtask

  task automatic drive(input logic [15:0] i, input logic l, input logic n, input logic c,
                       input logic pu, input logic po);
    pc_in = i; load = l; inc = n; clr = c;
    push = STK_EN ? pu : 1'b0;
    pop  = STK_EN ? po : 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.out", 32'(out), 32'h0000);
    chk("rst.wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // increment from zero
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step("inc");
      chk("inc.const", 32'(out), 32'(i));
    end

    // async reset mid-count, requests ignored while held
    drive(16'h0042, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld42");
    chk("ld42.const", 32'(out), 32'h0042);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.out", 32'(out), 32'h0000);
    chk("arst.wrap", 32'(wrap), 32'h0);
    drive(16'h0055, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("arst.hold", 32'(out), 32'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // wrap from all-ones
    drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ldffff");
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wrap");
    chk("wrap.out", 32'(out), 32'h0000);
    chk("wrap.pulse", 32'(wrap), 32'h1);
    step("postwrap");
    chk("postwrap.pulse", 32'(wrap), 32'h0);

    // priority
    drive(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ld+inc");
    chk("ld+inc.const", 32'(out), 32'h1234);
    drive(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("clr+all");
    chk("clr.const", 32'(out), 32'h0000);

`ifdef PC_CALL_STACK_EN
    // call / return
    drive(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld10");
    drive(16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("call");
    chk("call.const", 32'(out), 32'h0200);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("ret");
    chk("ret.const", 32'(out), 32'h0011);
    chk("ret.empty", 32'(stk_empty), 32'h1);

    // fill, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) begin
      drive(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("fill");
    end
    chk("fill.full", 32'(stk_full), 32'h1);
    drive(16'h0777, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ovf");
    chk("ovf.hold", 32'(out), 32'h0103);
    chk("ovf.err", 32'(stk_err), 32'h1);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ovf.after");
    chk("ovf.errclr", 32'(stk_err), 32'h0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain");
    drive(16'h0999, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("udf");
    chk("udf.err", 32'(stk_err), 32'h1);
    drive(16'h0300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("push1");
    drive(16'h0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("push+pop");
    chk("push+pop.err", 32'(stk_err), 32'h0);
`endif

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
